mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo up/down counter with synchronous load, variable step, terminal-count and wrap indication. It generalises the team's fixed 8-bit load/increment counter to arbitrary width and modulus, adds a down direction and a multi-count step, and flags out-of-range loads. It is used as a standalone sequencing and address counter in datapath blocks and as the DUT of the counter regression bench.

## Interface
Parameters:
- WIDTH, 8: counter and load-data width.
- MODULUS, 256: count range is 0..MODULUS-1. Legal range is 2..2**WIDTH.
- STEP_W, 4: step input width. The largest step, 2**STEP_W-1, must be less than MODULUS.
- Any illegal combination of WIDTH, MODULUS and STEP_W raises `$error` at elaboration.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous, active-low.
- ld, input, 1: load data_in into the counter.
- data_in, input, WIDTH: load value.
- en, input, 1: count enable.
- up, input, 1: direction; 1 counts up, 0 counts down.
- step, input, STEP_W: amount added or subtracted per enabled cycle.
- sat, input, 1: saturate instead of wrap. Present only with MOD_COUNTER_SAT_EN.
- q, output, WIDTH: counter value, registered.
- tc, output, 1: terminal count, combinational from q and up.
- wrap, output, 1: boundary event, registered one-cycle pulse.
- err, output, 1: out-of-range load, registered one-cycle pulse.

## Operation
- Priority order: rst, then ld, then en, then hold.
- rst=0: q, wrap and err all go to 0 at the edge. ld, en and step are ignored. Reset applied mid-count takes effect at the next edge with no residue.
- ld=1:
  - If data_in < MODULUS: q <= data_in and err <= 0.
  - Otherwise: q <= MODULUS-1 and err <= 1.
  - In both cases en and step are ignored and wrap <= 0.
- en=1, up=1: s = q + step, computed at WIDTH+1 bits.
  - If s >= MODULUS: q <= s - MODULUS and wrap <= 1.
  - Otherwise: q <= s and wrap <= 0.
- en=1, up=0:
  - If q < step: q <= q + MODULUS - step and wrap <= 1.
  - Otherwise: q <= q - step and wrap <= 0.
- step=0 with en=1: q holds and wrap=0.
- en=0 and ld=0: q holds; wrap and err are 0.
- tc = (up && q==MODULUS-1) || (!up && q==0).
- q never leaves 0..MODULUS-1.

## Timing
- The new q is visible one cycle after the ld or en edge.
- wrap and err assert in the same cycle as the q they describe and last exactly one cycle per event. Consecutive wrapping counts produce back-to-back pulses.
- tc follows q and up with zero latency and no registers.
- Inputs are sampled only at the rising edge of clk. There are no multicycle paths.

## Configuration
- MOD_COUNTER_SAT_EN defined:
  - The sat port exists.
  - When sat=1, an up count whose s >= MODULUS sets q <= MODULUS-1.
  - When sat=1, a down count with q < step sets q <= 0.
  - In both saturating cases wrap <= 1, including repeated attempts while already at the bound.
  - When sat=0, the counter wraps as described under Operation.
- MOD_COUNTER_SAT_EN undefined: the sat port is absent and the counter always wraps.

## Structure
- Package mod_counter_pkg holds:
  - the parameter-check function;
  - typedef `dir_e` (DOWN=0, UP=1);
  - a function computing the next value and boundary flag from (q, step, dir, sat, MODULUS).
- One combinational sub-module, mod_counter_next, wraps that function. The top module holds the registers, load clamping, priority logic and tc.

## Test plan
All scenarios use WIDTH=8, MODULUS=200, STEP_W=4.
- Reset: rst=0 for 2 cycles with ld=1, data_in=55 -> q=0, wrap=0, err=0. Release -> q=55 the next cycle.
- Up wrap: load 195, then en=1, up=1, step=3 -> q=198, wrap=0; then q=1, wrap=1; then q=4, wrap=0. tc=1 only when q=199 with up=1.
- Down wrap: load 2, then en=1, up=0, step=5 -> q=197, wrap=1. Load 0 with up=0 -> tc=1.
- Bad load: ld=1, data_in=250 -> q=199, err=1 for one cycle. A following load of 10 -> q=10, err=0.
- Simultaneous ld+en: data_in=10, step=7, up=1 -> q=10. Applying rst=0 with ld=1 and en=1 -> q=0.
- Saturate (MOD_COUNTER_SAT_EN): q=198, sat=1, up, step=4 -> q=199, wrap=1; again -> q=199, wrap=1. Down from q=3, step=9 -> q=0, wrap=1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
`default_nettype none
// mod_counter_pkg: direction type, parameter legality check and the shared
// next-count function used by mod_counter_next.
package mod_counter_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             boundary;
  } next_t;

  // Widths are capped at 62 so q + step can never overflow the 64-bit math.
  function automatic bit params_ok(input int width, input longint modulus, input int step_w);
    longint max_mod;
    longint max_step;
    if (width < 1 || width > 62 || step_w < 1 || step_w > 62) begin
      return 1'b0;
    end
    max_mod  = longint'(1) << width;
    max_step = (longint'(1) << step_w) - 1;
    return (modulus >= 2) && (modulus <= max_mod) && (max_step < modulus);
  endfunction

  function automatic next_t next_count(
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] step,
    input dir_e             dir,
    input logic             sat,
    input logic [MAX_W-1:0] modulus
  );
    next_t            r;
    logic [MAX_W-1:0] s;
    s          = q + step;
    r.value    = q;
    r.boundary = 1'b0;
    if (dir == UP) begin
      if (s >= modulus) begin
        r.boundary = 1'b1;
        r.value    = sat ? (modulus - 1) : (s - modulus);
      end else begin
        r.value = s;
      end
    end else begin
      if (q < step) begin
        r.boundary = 1'b1;
        r.value    = sat ? '0 : (q + modulus - step);
      end else begin
        r.value = q - step;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter_next.sv
`default_nettype none
// mod_counter_next: combinational next value and boundary flag for one
// enabled count, sized down from the package's 64-bit arithmetic.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256,
  parameter int     STEP_W  = 4
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [STEP_W-1:0] step_i,
  input  dir_e              dir_i,
  input  logic              sat_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              boundary_o
);

  localparam logic [MAX_W-1:0] c_mod = MAX_W'(MODULUS);

  next_t w_res;

  always_comb begin
    w_res = next_count(MAX_W'(q_i), MAX_W'(step_i), dir_i, sat_i, c_mod);
  end

  // Result is always below MODULUS <= 2**WIDTH, so truncation loses nothing.
  assign q_o        = WIDTH'(w_res.value);
  assign boundary_o = w_res.boundary;

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// mod_counter: modulo up/down counter with load clamping, step, tc, wrap and
// err pulses. Define MOD_COUNTER_SAT_EN to add the sat (saturate) input.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256,
  parameter int     STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
`ifdef MOD_COUNTER_SAT_EN
  input  logic              sat,
`endif
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              wrap,
  output logic              err
);

  if (!params_ok(WIDTH, MODULUS, STEP_W)) begin : g_param_err
    $error("mod_counter: illegal WIDTH/MODULUS/STEP_W combination");
  end

  localparam logic [MAX_W-1:0] c_mod = MAX_W'(MODULUS);
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] w_next_q;
  logic             w_next_bnd;
  logic             w_sat;
  logic             w_ld_ok;

`ifdef MOD_COUNTER_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .STEP_W  (STEP_W)
  ) u_next (
    .q_i        (q_q),
    .step_i     (step),
    .dir_i      (dir_e'(up)),
    .sat_i      (w_sat),
    .q_o        (w_next_q),
    .boundary_o (w_next_bnd)
  );

  assign w_ld_ok = (MAX_W'(data_in) < c_mod);

  // Load beats count; out-of-range loads clamp to the top of the range.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (ld) begin
      q_d   = w_ld_ok ? data_in : c_max;
      err_d = ~w_ld_ok;
    end else if (en) begin
      q_d    = w_next_q;
      wrap_d = w_next_bnd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;
  assign tc   = (up && (q_q == c_max)) || (!up && (q_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// tb_mod_counter: vector table, saturate sequence and randomized run against
// a modular-arithmetic reference model.
module tb_mod_counter;

  localparam int W  = 8;
  localparam int M  = 200;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld  = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          en  = 1'b0;
  logic          up  = 1'b1;
  logic [SW-1:0] step = '0;
  logic          sat = 1'b0;
  logic [W-1:0]  q;
  logic          tc, wrap, err;

  int n_total = 0;
  int n_pass  = 0;

  mod_counter #(.WIDTH(W), .MODULUS(M), .STEP_W(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .data_in (data_in),
    .en      (en),
    .up      (up),
    .step    (step),
`ifdef MOD_COUNTER_SAT_EN
    .sat     (sat),
`endif
    .q       (q),
    .tc      (tc),
    .wrap    (wrap),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ld;
    int         d;
    logic       en, up;
    int         st;
    int         q;
    logic       w, e, t;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int m_q = 0, m_w = 0, m_e = 0;

  task automatic model_step(input logic r, input logic l, input int d, input logic e,
                            input logic u, input int st, input logic s);
    int t;
    if (!r) begin
      m_q = 0; m_w = 0; m_e = 0;
    end else if (l) begin
      m_w = 0;
      m_e = (d >= M) ? 1 : 0;
      m_q = (d >= M) ? M - 1 : d;
    end else begin
      m_w = 0; m_e = 0;
      if (e) begin
        t   = u ? m_q + st : m_q - st;
        m_w = (t >= M || t < 0) ? 1 : 0;
        if (m_w != 0 && s) m_q = u ? M - 1 : 0;
        else               m_q = (t % M + M) % M;
      end
    end
  endtask

  initial begin
    // rst ld d en up st | q w e tc
    vecs.push_back('{0,1, 55,0,1,0,   0,0,0,0});
    vecs.push_back('{0,1, 55,0,1,0,   0,0,0,0});
    vecs.push_back('{1,1, 55,0,1,0,  55,0,0,0});
    vecs.push_back('{1,1,195,0,1,0, 195,0,0,0});
    vecs.push_back('{1,0,  0,1,1,3, 198,0,0,0});
    vecs.push_back('{1,0,  0,1,1,3,   1,1,0,0});
    vecs.push_back('{1,0,  0,1,1,3,   4,0,0,0});
    vecs.push_back('{1,1,196,0,1,0, 196,0,0,0});
    vecs.push_back('{1,0,  0,1,1,3, 199,0,0,1});
    vecs.push_back('{1,1,  2,0,0,0,   2,0,0,0});
    vecs.push_back('{1,0,  0,1,0,5, 197,1,0,0});
    vecs.push_back('{1,1,  0,0,0,0,   0,0,0,1});
    vecs.push_back('{1,1,250,0,1,0, 199,0,1,1});
    vecs.push_back('{1,1, 10,1,1,7,  10,0,0,0});
    vecs.push_back('{0,1, 77,1,1,7,   0,0,0,0});
    vecs.push_back('{1,0, 99,0,1,7,   0,0,0,0});
    vecs.push_back('{1,0,  0,1,1,0,   0,0,0,0});
    vecs.push_back('{1,1,200,0,0,0, 199,0,1,0});
    vecs.push_back('{1,1,199,0,1,0, 199,0,0,1});
    vecs.push_back('{1,0,  0,0,1,0, 199,0,0,1});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; ld = vecs[i].ld; data_in = W'(vecs[i].d);
      en = vecs[i].en; up = vecs[i].up; step = SW'(vecs[i].st);
      cyc();
      check($sformatf("vec%0d_q", i),    int'(q),    vecs[i].q);
      check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].w));
      check($sformatf("vec%0d_err", i),  int'(err),  int'(vecs[i].e));
      check($sformatf("vec%0d_tc", i),   int'(tc),   int'(vecs[i].t));
    end

`ifdef MOD_COUNTER_SAT_EN
    rst = 1; ld = 1; en = 0; data_in = 198; up = 1; sat = 1; cyc();
    ld = 0; en = 1; step = 4; cyc();
    check("sat_up_q", int'(q), 199);
    check("sat_up_wrap", int'(wrap), 1);
    cyc();
    check("sat_up2_q", int'(q), 199);
    check("sat_up2_wrap", int'(wrap), 1);
    ld = 1; en = 0; data_in = 3; cyc();
    ld = 0; en = 1; up = 0; step = 9; cyc();
    check("sat_dn_q", int'(q), 0);
    check("sat_dn_wrap", int'(wrap), 1);
    sat = 0;
`endif

    // Randomized run; start from a reset so the model is in step.
    rst = 0; ld = 0; en = 0; cyc();
    model_step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic s_eff;
      rst     = ($urandom_range(99) >= 4);
      ld      = ($urandom_range(99) < 15);
      en      = ($urandom_range(99) < 70);
      up      = $urandom_range(1);
      step    = SW'($urandom_range(15));
      data_in = W'($urandom_range(255));
`ifdef MOD_COUNTER_SAT_EN
      sat     = $urandom_range(1);
      s_eff   = sat;
`else
      s_eff   = 1'b0;
`endif
      model_step(rst, ld, int'(data_in), en, up, int'(step), s_eff);
      cyc();
      check("rnd_q",    int'(q),    m_q);
      check("rnd_wrap", int'(wrap), m_w);
      check("rnd_err",  int'(err),  m_e);
      check("rnd_tc",   int'(tc),   ((up && m_q == M - 1) || (!up && m_q == 0)) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
